// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_reader
//  Description : Samples a multiplexed 3-digit seven-segment bus, decodes it
//                to BCD and publishes a value after N identical valid frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_reader #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic [2:0] dig_sel,
    input  logic [6:0] seg,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hund,
    output logic [9:0] value,
    output logic       valid,
    output logic       upd,
    output logic       frame_err,
    output logic       sel_err
);

    localparam logic [2:0] c_cnt_max = 3'(STABLE_FRAMES);
    localparam logic [3:0] c_bad     = 4'hF;

    logic [3:0] r_slot_u, r_slot_t, r_slot_h;
    logic [3:0] r_prev_u, r_prev_t, r_prev_h;
    logic       r_prev_ok;
    logic [2:0] r_mask;
    logic [2:0] r_cnt;
    logic [3:0] r_units, r_tens, r_hund;
    logic [9:0] r_value;
    logic       r_valid, r_upd, r_frame_err, r_sel_err;

    logic [3:0] w_dig;
    logic       w_onehot;
    logic       w_capture;
    logic       w_frame_done;
    logic       w_frame_bad;
    logic       w_match;
    logic       w_differs;
    logic [2:0] w_cnt_next;
    logic [2:0] w_mask_next;
    logic [9:0] w_frame_value;

    always_comb begin
        w_dig = c_bad;
        case (seg)
            7'b1111110: w_dig = 4'd0;
            7'b0110000: w_dig = 4'd1;
            7'b1101101: w_dig = 4'd2;
            7'b1111001: w_dig = 4'd3;
            7'b0110011: w_dig = 4'd4;
            7'b1011011: w_dig = 4'd5;
            7'b1011111: w_dig = 4'd6;
            7'b1110000: w_dig = 4'd7;
            7'b1111111: w_dig = 4'd8;
            7'b1111011: w_dig = 4'd9;
            default:    w_dig = c_bad;
        endcase
    end

    assign w_onehot     = (dig_sel == 3'b001) || (dig_sel == 3'b010) || (dig_sel == 3'b100);
    assign w_capture    = strobe && w_onehot;
    assign w_frame_done = (r_mask == 3'b111);
    assign w_frame_bad  = (r_slot_u == c_bad) || (r_slot_t == c_bad) || (r_slot_h == c_bad);
    assign w_match      = r_prev_ok && (r_slot_u == r_prev_u) && (r_slot_t == r_prev_t)
                          && (r_slot_h == r_prev_h);
    assign w_differs    = (r_slot_u != r_units) || (r_slot_t != r_tens) || (r_slot_h != r_hund);
    assign w_frame_value = {6'd0, r_slot_h} * 10'd100 + {6'd0, r_slot_t} * 10'd10
                           + {6'd0, r_slot_u};

    always_comb begin
        w_cnt_next = 3'd1;
        if (w_match) begin
            w_cnt_next = (r_cnt >= c_cnt_max) ? c_cnt_max : r_cnt + 3'd1;
        end
    end

    // A strobe landing on the processing edge opens the next frame.
    always_comb begin
        w_mask_next = w_frame_done ? 3'b000 : r_mask;
        if (w_capture) begin
            w_mask_next = w_mask_next | dig_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_u    <= 4'd0;
            r_slot_t    <= 4'd0;
            r_slot_h    <= 4'd0;
            r_prev_u    <= 4'd0;
            r_prev_t    <= 4'd0;
            r_prev_h    <= 4'd0;
            r_prev_ok   <= 1'b0;
            r_mask      <= 3'b000;
            r_cnt       <= 3'd0;
            r_units     <= 4'd0;
            r_tens      <= 4'd0;
            r_hund      <= 4'd0;
            r_value     <= 10'd0;
            r_valid     <= 1'b0;
            r_upd       <= 1'b0;
            r_frame_err <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_upd       <= 1'b0;
            r_frame_err <= 1'b0;
            r_sel_err   <= strobe && !w_onehot;
            r_mask      <= w_mask_next;

            if (w_frame_done) begin
                if (w_frame_bad) begin
                    r_cnt       <= 3'd0;
                    r_frame_err <= 1'b1;
                    r_prev_ok   <= 1'b0;
                end else begin
                    r_cnt     <= w_cnt_next;
                    r_prev_u  <= r_slot_u;
                    r_prev_t  <= r_slot_t;
                    r_prev_h  <= r_slot_h;
                    r_prev_ok <= 1'b1;
                    if (w_cnt_next == c_cnt_max) begin
                        r_units <= r_slot_u;
                        r_tens  <= r_slot_t;
                        r_hund  <= r_slot_h;
                        r_value <= w_frame_value;
                        r_valid <= 1'b1;
                        r_upd   <= !r_valid || w_differs;
                    end
                end
            end

            // Slot writes read-after the frame compare above, so latest wins.
            if (w_capture) begin
                case (dig_sel)
                    3'b001:  r_slot_u <= w_dig;
                    3'b010:  r_slot_t <= w_dig;
                    3'b100:  r_slot_h <= w_dig;
                    default: r_slot_u <= r_slot_u;
                endcase
            end
        end
    end

    assign units     = r_units;
    assign tens      = r_tens;
    assign hund      = r_hund;
    assign value     = r_value;
    assign valid     = r_valid;
    assign upd       = r_upd;
    assign frame_err = r_frame_err;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side block for the three-digit seven-segment display bus driven by the 0–999 counter. It samples a time-multiplexed segment bus (one digit per strobe), decodes each segment pattern back to BCD, and assembles units/tens/hundreds into a frame. A value is published only after a parameterised number of identical, error-free frames. The published value is given both as BCD and as binary, for checkers and for downstream logic that consumes the displayed count.

## Interface
- STABLE_FRAMES, default 2: consecutive identical valid frames required before publishing; legal range 1..4.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- strobe  in  1  seg/dig_sel valid this cycle.
- dig_sel  in  3  one-hot digit select: bit0 units, bit1 tens, bit2 hundreds.
- seg  in  7  segment pattern {a,b,c,d,e,f,g}; a = bit6, g = bit0; 1 = segment lit.
- units  out  4  published units BCD.
- tens  out  4  published tens BCD.
- hund  out  4  published hundreds BCD.
- value  out  10  published binary value, hund*100 + tens*10 + units (0..999).
- valid  out  1  high once any value has been published; cleared only by rst.
- upd  out  1  one-cycle pulse when published value changes (or on the first publish).
- frame_err  out  1  one-cycle pulse when a completed frame contains an undecodable digit.
- sel_err  out  1  one-cycle pulse on a strobe whose dig_sel is not one-hot.

## Operation
- Decode table (seg -> BCD): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
- Any other pattern decodes to 4'hF and is marked bad. The reverse-E pattern 1111001 collides with 3 and decodes as 3.
- Strobe with one-hot dig_sel: the decoded digit is written into the frame slot for that digit, and the slot bit is set in capture mask[2:0].
- Re-strobing a slot already captured in the current frame overwrites it (latest wins).
- Strobe with non-one-hot dig_sel (including 000): no capture; sel_err pulses.
- Frame complete: mask = 111. Digits may arrive in any order.
- Match counter cnt (0..STABLE_FRAMES) on each complete frame:
  - frame has a bad digit: cnt=0, frame_err pulses, previous-frame record invalidated.
  - frame equals previous valid frame: cnt=min(cnt+1, STABLE_FRAMES).
  - otherwise: cnt=1.
  - The frame is then stored as the previous frame.
- Publish: when updated cnt == STABLE_FRAMES, load units/tens/hund/value from the frame and set valid.
  - upd pulses if the loaded value differs from the held outputs, or if valid was 0.
- With STABLE_FRAMES=1, every error-free frame publishes.
- Outputs hold between publishes; error frames never change them.

## Timing
- Reset values: units=tens=hund=0, value=0, valid=0, upd=0, frame_err=0, sel_err=0, mask=000, cnt=0, previous frame invalid.
- Capture: strobe sampled at edge N updates slot/mask at edge N. sel_err is high during cycle N+1.
- Let E be the edge at which mask becomes 111. At edge E+1:
  - compare, update cnt, publish if due, clear mask.
  - upd/frame_err are high during cycle E+2.
  - units/tens/hund/value are valid from E+1.
- Latency from the final digit strobe to published outputs: 2 edges.
- Strobe coinciding with frame processing (sampled at E+1): it starts the next frame. The mask after E+1 equals that digit's bit only.
- rst mid-frame: the partial frame is discarded, all state returns to reset values, and the next strobe starts a fresh frame.
- Throughput: one strobe per cycle; back-to-back complete frames every 3 cycles are supported.

## Test plan
- Reset, then strobe units=1011011, tens=0110000, hund=1101101 twice (STABLE_FRAMES=2):
  - no publish after frame 1;
  - after frame 2: hund=2, tens=1, units=5, value=215, valid=1, upd one pulse.
- Repeat the same 215 frame a third time -> outputs unchanged, upd stays 0, cnt saturates at 2.
- Frame with tens seg=0000001 -> frame_err pulse, outputs hold 215. The next two valid frames of 999 -> value=999, upd pulse.
- Strobe with dig_sel=011 -> sel_err pulse, mask unchanged. Frames alternating 123/124 -> never publish.
- Send hund and tens, assert rst, then send units only -> no publish. After a full 000 frame pair: value=0, valid=1, upd pulse.
- STABLE_FRAMES=1: digits in order hund, units, tens for 987 -> value=987 at E+1, upd high in cycle E+2. A strobe at E+1 leaves mask = that digit's bit only.
